// File: rtl/serial_tl_host_pkg.sv
// Shared constants and types for the serial TileLink host controller:
// register map, STATUS/CTRL bit positions and the Wishbone FSM states.
package serial_tl_host_pkg;

    // Register offsets, decoded from wbs_adr_i[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_COUNT_LSB = 0;
    localparam int ST_RX_COUNT_LSB = 4;
    localparam int ST_TX_FULL      = 8;
    localparam int ST_TX_EMPTY     = 9;
    localparam int ST_RX_FULL      = 10;
    localparam int ST_RX_EMPTY     = 11;
    localparam int ST_TX_OVF       = 16;
    localparam int ST_RX_UDF       = 17;

    // CTRL bit positions
    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_FLUSH     = 1;
    localparam int CTRL_IRQ_RX_EN = 2;
    localparam int CTRL_IRQ_TX_EN = 3;

    // Wishbone slave FSM: one ack per accepted request
    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/serial_tl_host_ctrl_sync_fifo.sv
// Single-clock FIFO with pre-edge full/empty guarding and a synchronous
// flush that overrides any push or pop in the same cycle. The head word
// reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_COUNT = DEPTH[PW:0];
    localparam logic [PW:0]   COUNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE    = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; the head is masked by
        // empty, so stale contents are never observable.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_tl_host_ctrl.sv
// Wishbone slave that queues management-core writes onto the inbound serial
// TileLink channel and buffers the outbound channel for Wishbone reads.
module serial_tl_host_ctrl
    import serial_tl_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tl_in_valid_o,
    input  logic        tl_in_ready_i,
    output logic [31:0] tl_in_bits_o,
    input  logic        tl_out_valid_i,
    output logic        tl_out_ready_o,
    input  logic [31:0] tl_out_bits_i,
    output logic        irq_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_state_t      state;
    wb_state_t      state_next;
    logic           req_held;
    logic           sel_hit;
    logic           req;
    logic           access;
    logic           wr;
    logic           rd;
    logic [1:0]     reg_sel;
    logic [31:0]    wdata;
    logic [31:0]    rdata;
    logic [31:0]    status_word;
    logic [31:0]    dat_q;

    logic           enable;
    logic           irq_rx_en;
    logic           irq_tx_en;
    logic           tx_ovf;
    logic           rx_udf;

    logic           flush;
    logic           tx_push;
    logic           tx_pop;
    logic           rx_push;
    logic           rx_pop;
    logic           tx_full;
    logic           tx_empty;
    logic           rx_full;
    logic           rx_empty;
    logic [CW-1:0]  tx_count;
    logic [CW-1:0]  rx_count;
    logic [31:0]    tx_head;
    logic [31:0]    rx_head;

    // Word-aligned registers: the byte offset bits carry no information
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[1:0];

    assign sel_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req     = wbs_stb_i & wbs_cyc_i & sel_hit;
    assign reg_sel = wbs_adr_i[3:2];
    assign wr      = access & wbs_we_i;
    assign rd      = access & ~wbs_we_i;

    // Byte lanes that are not selected are written as zero
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        wdata = '0;
        for (int b = 0; b < 4; b++) begin
            wdata[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : 8'h00;
        end
    end

    // Wishbone FSM next state; the register access happens on the IDLE->ACK edge
    always_comb begin
        state_next = state;
        access     = 1'b0;
        case (state)
            WB_IDLE: begin
                if (req && !req_held) begin
                    state_next = WB_ACK;
                    access     = 1'b1;
                end
            end
            WB_ACK:  state_next = WB_IDLE;
            default: state_next = WB_IDLE;
        endcase
    end

    // FSM state, held-strobe suppression and registered read data
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= WB_IDLE;
            req_held <= 1'b0;
            dat_q    <= '0;
        end else begin
            state    <= state_next;
            // A strobe still high after its ack is the same request, not a new one
            req_held <= ((state == WB_ACK) | req_held) & wbs_stb_i & wbs_cyc_i;
            dat_q    <= rd ? rdata : '0;
        end
    end

    // Register-side FIFO strobes; the FIFOs themselves drop push-when-full
    // and pop-when-empty
    assign tx_push = wr && (reg_sel == REG_TXDATA);
    assign rx_pop  = rd && (reg_sel == REG_RXDATA);
    assign flush   = wr && (reg_sel == REG_CTRL) && wdata[CTRL_FLUSH];

    // Channel handshakes, all qualified by registered state only
    assign tl_in_valid_o  = enable & ~tx_empty;
    assign tl_in_bits_o   = tx_head;
    assign tl_out_ready_o = enable & ~rx_full;
    assign tx_pop         = tl_in_valid_o & tl_in_ready_i;
    assign rx_push        = tl_out_ready_o & tl_out_valid_i;

    assign irq_o = enable & ((irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty));

    // STATUS word assembly and read-data mux
    always_comb begin
        status_word = '0;
        status_word[ST_TX_COUNT_LSB +: CW] = tx_count;
        status_word[ST_RX_COUNT_LSB +: CW] = rx_count;
        status_word[ST_TX_FULL]  = tx_full;
        status_word[ST_TX_EMPTY] = tx_empty;
        status_word[ST_RX_FULL]  = rx_full;
        status_word[ST_RX_EMPTY] = rx_empty;
        status_word[ST_TX_OVF]   = tx_ovf;
        status_word[ST_RX_UDF]   = rx_udf;

        rdata = '0;
        case (reg_sel)
            REG_TXDATA: rdata = '0;
            REG_RXDATA: rdata = rx_head;
            REG_STATUS: rdata = status_word;
            REG_CTRL: begin
                rdata[CTRL_ENABLE]    = enable;
                rdata[CTRL_IRQ_RX_EN] = irq_rx_en;
                rdata[CTRL_IRQ_TX_EN] = irq_tx_en;
            end
            default:    rdata = '0;
        endcase
    end

    // CTRL fields and sticky error flags
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            enable    <= 1'b0;
            irq_rx_en <= 1'b0;
            irq_tx_en <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_udf    <= 1'b0;
        end else begin
            if (wr && (reg_sel == REG_CTRL)) begin
                enable    <= wdata[CTRL_ENABLE];
                irq_rx_en <= wdata[CTRL_IRQ_RX_EN];
                irq_tx_en <= wdata[CTRL_IRQ_TX_EN];
            end
            if (tx_push && tx_full)
                tx_ovf <= 1'b1;
            else if (wr && (reg_sel == REG_STATUS) && wdata[ST_TX_OVF])
                tx_ovf <= 1'b0;
            if (rx_pop && rx_empty)
                rx_udf <= 1'b1;
            else if (wr && (reg_sel == REG_STATUS) && wdata[ST_RX_UDF])
                rx_udf <= 1'b0;
        end
    end

    assign wbs_ack_o = (state == WB_ACK);
    assign wbs_dat_o = dat_q;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush),
        .din   (wdata),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush),
        .din   (tl_out_bits_i),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule

// File: doc/serial_tl_host_ctrl.md
# serial_tl_host_ctrl

Wishbone-slave controller that lets the management core drive the SoC's 32-bit serial TileLink port. Words written over Wishbone are queued and presented on the inbound serial channel with a valid/ready handshake; words returned on the outbound channel are buffered for Wishbone reads. It sits in the user project wrapper between the Caravel Wishbone bus and ChipTop's `serial_tl_bits_in_*` / `serial_tl_bits_out_*` ports.

## Interface
- `BASE_ADDR`, 32'h3000_0000, block is selected when `wbs_adr_i[31:4] == BASE_ADDR[31:4]`
- `DEPTH`, 4, entries per FIFO (power of two, ≥2)
- `wb_clk_i` in 1, single clock
- `wb_rst_i` in 1, reset, asynchronous, active-high
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each, Wishbone classic strobe, cycle, write
- `wbs_sel_i` in 4, byte lanes
- `wbs_adr_i`, `wbs_dat_i` in 32 each, address, write data
- `wbs_ack_o` out 1, single-cycle ack
- `wbs_dat_o` out 32, read data, valid with ack
- `tl_in_valid_o` out 1, `tl_in_ready_i` in 1, `tl_in_bits_o` out 32, inbound channel to ChipTop
- `tl_out_valid_i` in 1, `tl_out_ready_o` out 1, `tl_out_bits_i` in 32, outbound channel from ChipTop
- `irq_o` out 1, level interrupt

## Operation
- Registers are decoded by `wbs_adr_i[3:2]`:
  - 0 TXDATA, write-only: push one word to the TX FIFO. Byte lanes with `sel` = 0 are pushed as 0x00.
  - 1 RXDATA, read-only: pop the RX FIFO head.
  - 2 STATUS:
    - [2:0] tx_count, [6:4] rx_count
    - 8 tx_full, 9 tx_empty, 10 rx_full, 11 rx_empty
    - 16 tx_ovf, 17 rx_udf; both sticky, write-1-to-clear
  - 3 CTRL: 0 enable, 1 flush (self-clearing, reads 0), 2 irq_rx_en, 3 irq_tx_en.
- Wishbone FSM has states IDLE and ACK.
  - IDLE→ACK when `stb & cyc & selected`. The register access is performed on that edge.
  - ACK→IDLE unconditionally, so exactly one ack is produced per request even if `stb` is held.
  - Unselected addresses get no ack.
- TXDATA write while TX is full: word dropped, tx_ovf set, still acked.
- RXDATA read while RX is empty: returns 0, rx_udf set, no pop.
- Reads of TXDATA return 0. Writes to RXDATA are ignored. Both are acked.
- `tl_in_valid_o = enable & !tx_empty`, and `tl_in_bits_o` = TX head. A pop occurs when valid & `tl_in_ready_i`.
- `tl_out_ready_o = enable & !rx_full`. A push occurs when ready & `tl_out_valid_i`.
- enable = 0 stalls both channels; FIFO contents are retained.
- Flush empties both FIFOs on the same edge as the CTRL write. It does not clear the sticky bits. A channel transfer in that same cycle is discarded.
- `irq_o = enable & ((irq_rx_en & !rx_empty) | (irq_tx_en & tx_empty))`.

## Timing
- Reset values:
  - `wbs_ack_o` = 0, `wbs_dat_o` = 0
  - `tl_in_valid_o` = 0, `tl_out_ready_o` = 0, `irq_o` = 0
  - `tl_in_bits_o` = 0
  - FIFOs empty, CTRL = 0, sticky bits = 0
- Wishbone latency: ack and read data are registered and appear 1 cycle after the request edge. `wbs_dat_o` returns to 0 when ack is low.
- Full/empty and count are evaluated from the pre-edge state:
  - TX full: a Wishbone push is dropped even if a serial pop occurs in the same cycle.
  - TX not full: a simultaneous push and pop leaves the count unchanged.
  - RX: the same rules apply with the roles swapped.
- Channel outputs are combinational from registered state, with no combinational path from `*_ready_i`/`*_valid_i` to the outputs.
- Pointers wrap modulo DEPTH. Counts range 0..DEPTH and are carried in log2(DEPTH)+1 bits.
- Reset mid-transfer: everything returns to reset values immediately (async). A pending ack is lost.

## Structure
- Package `serial_tl_host_pkg` holds:
  - register offsets (TXDATA/RXDATA/STATUS/CTRL)
  - STATUS/CTRL bit positions
  - the Wishbone FSM state enum
- Sub-module `sync_fifo` (parameters: width, DEPTH; ports: push/pop, data, full/empty/count, flush) is instantiated twice, once for TX and once for RX.

## Test plan
- **Loopback path**: write CTRL=1, write TXDATA 0xDEADBEEF, hold `tl_in_ready_i`=1 → `tl_in_bits_o`=0xDEADBEEF valid for 1 cycle, STATUS tx_empty=1.
- **TX overflow**: with enable=0, write 5 words → STATUS tx_count=4, tx_ovf=1. Write STATUS bit16=1 → tx_ovf=0. Set enable → words 1–4 emitted in order.
- **RX path and underflow**: drive `tl_out_bits_i`=0x12345678 valid 1 cycle → rx_count=1. RXDATA read returns 0x12345678. A second read returns 0 and sets rx_udf.
- **Backpressure and simultaneity**: RX full (4 words), then `tl_out_ready_o`=0. Pop via Wishbone while `tl_out_valid_i`=1 → the new word is accepted the cycle after the pop, and rx_count stays 4.
- **Ack protocol and flush**: hold `stb`/`cyc` for 4 cycles → exactly one ack, 1 cycle after the request. CTRL write with flush=1 and enable=1 → both counts 0, CTRL reads back 0x1, and `irq_o` follows the irq_tx_en setting.
- **Async reset**: assert `wb_rst_i` mid-transfer → all outputs 0 without waiting for a clock edge.
